fc1_layer: RTL and testbench
============================

Name: fc1_layer

Overview:
- First fully-connected layer of the classifier head; sits directly upstream of the second FC stage.
- Reads an int8 activation vector from the shared activation RAM, then computes N_OUT neurons by serial MAC against int8 weights held in weight ROM.
- Requantizes each accumulator with per-neuron 32-bit parameters (fixed-point scale, zero-point correction, bias).
- Writes N_OUT int8 results to activation RAM at OUT_BASE, which is where the second FC stage reads its input vector.

Parameters:
- N_IN, 48, input vector length
- N_OUT, 12, output neurons
- IN_BASE, 16'h0000, RAM address of input element 0
- OUT_BASE, 16'h8000, RAM address of output element 0
- W_BASE, 21288, weight ROM address of neuron 0 weight 0; weight (n,k) is at W_BASE + n*N_IN + k
- Q_BASE, 108, parameter ROM address of neuron 0; word n*3+0 = scale q0, +1 = zero correction q1, +2 = bias q2
- RD_LAT, 2, cycles from registered address/enable to valid read data, for all memories

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run the layer
- busy  out  1  high while the layer is running
- done  out  1  one-cycle pulse when the run completes
- ram_addr_r  out  16  activation RAM read address
- ram_en_r  out  1  activation RAM read enable
- ram_data_r  in  8  activation RAM read data (signed)
- rom_addr_w  out  16  weight ROM address
- rom_en_w  out  1  weight ROM enable
- rom_data_w  in  8  weight data (signed)
- rom_addr_q  out  9  parameter ROM address
- rom_en_q  out  1  parameter ROM enable
- rom_data_q  in  32  parameter data (signed)
- ram_addr_w  out  16  activation RAM write address
- ram_data_w  out  8  write data (signed)
- ram_en  out  1  RAM write-port enable
- ram_wea  out  1  RAM write strobe

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: all outputs 0; state IDLE; neuron counter 0; accumulator 0.
- States: IDLE -> LOAD_Q -> MAC -> REQ -> WRITE -> (LOAD_Q for the next neuron | FINISH) -> IDLE.
- IDLE:
  - start=1 -> LOAD_Q with n=0; busy rises the next cycle.
  - start is ignored in every other state.
- LOAD_Q:
  - Issues q0, q1, q2 addresses on 3 consecutive cycles, with rom_en_q=1 during those 3 cycles only.
  - Captures each word RD_LAT cycles after its address is issued.
  - Lasts RD_LAT+3 cycles.
- MAC:
  - Cycle k (0..N_IN-1) issues ram_addr_r = IN_BASE+k and rom_addr_w = W_BASE+n*N_IN+k, with both enables high.
  - The accumulator clears on MAC entry.
  - Data returning at cycle k+RD_LAT adds sign-extended (x*w), a 16-bit product, into the 32-bit signed accumulator, which wraps on overflow.
  - Lasts N_IN+RD_LAT cycles.
- REQ, 4 fixed cycles:
  1. t = acc - q1 + q2, 32-bit wrap.
  2. p = t*q0, full signed 64-bit product.
  3. r = (p >>> 32) + p[31], round-half-up.
  4. out = -128 if r <= 0; 127 if r >= 255; otherwise r-128.
- WRITE:
  - One cycle with ram_en=ram_wea=1, ram_addr_w = OUT_BASE+n, ram_data_w = out.
  - ram_en and ram_wea are 0 in all other cycles.
  - Then n increments; if n = N_OUT-1, go to FINISH, otherwise go to LOAD_Q.
- FINISH: one cycle with done=1 and busy=0, then IDLE.
- Cycles per neuron: 2*RD_LAT + N_IN + 8. With defaults that is 60 per neuron, 720 from the start cycle to the last WRITE, and done follows on cycle 721.
- Reset mid-run aborts immediately; no further writes occur; the outputs written so far are not restored.
- start asserted in the same cycle as done is ignored; the block re-accepts start from IDLE.

Optional Feature:
- Macro: FC1_INPUT_BUF_EN.
- Defined:
  - An internal N_IN x 8 register buffer captures the input vector during neuron 0's MAC.
  - For neurons 1..N_OUT-1, ram_en_r stays 0 and the buffer supplies x.
  - Weight addressing, MAC timing, cycle counts and results are identical to the undefined build.
- Undefined: inputs are re-read from RAM for every neuron, and the buffer is absent.

Test Plan:
- All x=0, all q1=q2=0, q0=0x4000_0000 -> every output -128; 12 writes at 0x8000..0x800B; done on cycle 721 after start.
- All x=1, all w=1, q0=0x4000_0000, q1=q2=0 -> acc=48, r=12, every output -116 (0x8C).
- x=127, w=127 everywhere, q0=0x4000_0000 -> r=193548 -> output saturates to 127.
- Neuron with acc=2, q0=0x4000_0000 (p=2^31) -> rounding gives r=1, output -127; q1=3, q2=0 on the same neuron gives t=-1 -> output -128.
- start re-pulsed at cycle 100 of a run -> ignored: still exactly 12 writes and a single done pulse; with FC1_INPUT_BUF_EN, ram_en_r is high for exactly 48 cycles per run.
- rst_n low at cycle 300 -> all outputs 0 asynchronously; no writes after reset; a new start produces a correct full run.

Source files
------------

// File: rtl/fc1_layer.sv
// First FC layer of the classifier head: serial int8 MAC per neuron, 32-bit requantize, int8 writeback.
// Optional FC1_INPUT_BUF_EN keeps the input vector in registers after neuron 0 so RAM is read only once per run.
module fc1_layer #(
  parameter int          N_IN     = 48,
  parameter int          N_OUT    = 12,
  parameter logic [15:0] IN_BASE  = 16'h0000,
  parameter logic [15:0] OUT_BASE = 16'h8000,
  parameter int          W_BASE   = 21288,
  parameter int          Q_BASE   = 108,
  parameter int          RD_LAT   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [15:0]        ram_addr_r,
  output logic               ram_en_r,
  input  logic signed [7:0]  ram_data_r,
  output logic [15:0]        rom_addr_w,
  output logic               rom_en_w,
  input  logic signed [7:0]  rom_data_w,
  output logic [8:0]         rom_addr_q,
  output logic               rom_en_q,
  input  logic signed [31:0] rom_data_q,
  output logic [15:0]        ram_addr_w,
  output logic signed [7:0]  ram_data_w,
  output logic               ram_en,
  output logic               ram_wea
);

  localparam int CW = $clog2(N_IN + RD_LAT + 4);
  localparam int NW = $clog2(N_OUT + 1);
  localparam int KW = $clog2(N_IN);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_Q = 3'd1;
  localparam logic [2:0] MAC    = 3'd2;
  localparam logic [2:0] REQ    = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] FINISH = 3'd5;

  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic [NW-1:0]       n;
  logic signed [31:0]  acc, q0, q1, q2, t;
  logic signed [63:0]  p;
  logic signed [32:0]  r;
  logic signed [7:0]   out8;
  logic signed [7:0]   x_in;
  logic signed [15:0]  prod;
  logic                rd_x;
  logic                mac_data;
  logic [KW-1:0]       kx;

  // Data for issue slot k arrives RD_LAT cycles later, when cnt = k + RD_LAT.
  assign mac_data = (cnt >= CW'(RD_LAT)) && (cnt < CW'(N_IN + RD_LAT));
  assign kx       = KW'(cnt - CW'(RD_LAT));

`ifdef FC1_INPUT_BUF_EN
  logic signed [7:0] xbuf [N_IN];

  always_ff @(posedge clk) begin
    if (state == MAC && n == '0 && mac_data)
      xbuf[kx] <= ram_data_r;
  end

  assign rd_x = (n == '0);
  assign x_in = rd_x ? ram_data_r : xbuf[kx];
`else
  assign rd_x = 1'b1;
  assign x_in = ram_data_r;
`endif

  assign prod = x_in * rom_data_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      n     <= '0;
      acc   <= '0;
      q0    <= '0;
      q1    <= '0;
      q2    <= '0;
      t     <= '0;
      p     <= '0;
      r     <= '0;
      out8  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD_Q;
          cnt   <= '0;
          n     <= '0;
        end
        LOAD_Q: begin
          if (cnt == CW'(RD_LAT))     q0 <= rom_data_q;
          if (cnt == CW'(RD_LAT + 1)) q1 <= rom_data_q;
          if (cnt == CW'(RD_LAT + 2)) begin
            q2    <= rom_data_q;
            state <= MAC;
            cnt   <= '0;
            acc   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MAC: begin
          if (mac_data) acc <= acc + 32'(prod);
          if (cnt == CW'(N_IN + RD_LAT - 1)) begin
            state <= REQ;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          case (cnt[1:0])
            2'd0: t <= acc - q1 + q2;
            2'd1: p <= 64'(t) * 64'(q0);
            2'd2: r <= $signed({p[63], p[63:32]}) + $signed({32'd0, p[31]});
            default: begin
              if (r <= 33'sd0)        out8 <= -8'sd128;
              else if (r >= 33'sd255) out8 <= 8'sd127;
              else                    out8 <= $signed(r[7:0] ^ 8'h80);
              state <= WRITE;
              cnt   <= '0;
            end
          endcase
        end
        WRITE: begin
          if (n == NW'(N_OUT - 1)) begin
            state <= FINISH;
          end else begin
            n     <= n + 1'b1;
            state <= LOAD_Q;
          end
          cnt <= '0;
        end
        FINISH: begin
          state <= IDLE;
          n     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    ram_addr_r = '0;
    ram_en_r   = 1'b0;
    rom_addr_w = '0;
    rom_en_w   = 1'b0;
    rom_addr_q = '0;
    rom_en_q   = 1'b0;
    ram_addr_w = '0;
    ram_data_w = '0;
    ram_en     = 1'b0;
    ram_wea    = 1'b0;
    case (state)
      LOAD_Q: begin
        busy = 1'b1;
        if (cnt < CW'(3)) begin
          rom_en_q   = 1'b1;
          rom_addr_q = 9'(Q_BASE) + 9'(n) * 9'd3 + 9'(cnt);
        end
      end
      MAC: begin
        busy = 1'b1;
        if (cnt < CW'(N_IN)) begin
          rom_en_w   = 1'b1;
          rom_addr_w = 16'(W_BASE) + 16'(n) * 16'(N_IN) + 16'(cnt);
          if (rd_x) begin
            ram_en_r   = 1'b1;
            ram_addr_r = IN_BASE + 16'(cnt);
          end
        end
      end
      REQ: busy = 1'b1;
      WRITE: begin
        busy       = 1'b1;
        ram_en     = 1'b1;
        ram_wea    = 1'b1;
        ram_addr_w = OUT_BASE + 16'(n);
        ram_data_w = out8;
      end
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fc1_layer.sv
// Scoreboard bench for fc1_layer: directed vectors, expected writes queued by stimulus, checked by a monitor.
module tb_fc1_layer;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               busy, done;
  logic [15:0]        ram_addr_r, rom_addr_w, ram_addr_w;
  logic               ram_en_r, rom_en_w, rom_en_q, ram_en, ram_wea;
  logic signed [7:0]  ram_data_r, rom_data_w, ram_data_w;
  logic [8:0]         rom_addr_q;
  logic signed [31:0] rom_data_q;

  localparam int W_BASE = 21288;
  localparam int Q_BASE = 108;
`ifdef FC1_INPUT_BUF_EN
  localparam int EXP_EN = 48;
`else
  localparam int EXP_EN = 576;
`endif

  fc1_layer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ram_addr_r(ram_addr_r), .ram_en_r(ram_en_r), .ram_data_r(ram_data_r),
    .rom_addr_w(rom_addr_w), .rom_en_w(rom_en_w), .rom_data_w(rom_data_w),
    .rom_addr_q(rom_addr_q), .rom_en_q(rom_en_q), .rom_data_q(rom_data_q),
    .ram_addr_w(ram_addr_w), .ram_data_w(ram_data_w), .ram_en(ram_en), .ram_wea(ram_wea)
  );

  always #5 clk = ~clk;

  logic [7:0]  xmem [65536];
  logic [7:0]  wmem [65536];
  logic [31:0] qmem [512];
  logic [7:0]  x1, x2, w1, w2;
  logic [31:0] qa, qb;

  // Two-stage read pipeline models RD_LAT = 2 for all memories.
  always @(posedge clk) begin
    x1 <= ram_en_r ? xmem[ram_addr_r] : 8'h5A;
    w1 <= rom_en_w ? wmem[rom_addr_w] : 8'hA5;
    qa <= rom_en_q ? qmem[rom_addr_q] : 32'hDEAD_BEEF;
    x2 <= x1;
    w2 <= w1;
    qb <= qa;
  end
  assign ram_data_r = x2;
  assign rom_data_w = w2;
  assign rom_data_q = qb;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, s_cyc = 0, done_cyc = 0;
  int wr_cnt = 0, done_cnt = 0, enr_cnt = 0;
  logic [23:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [23:0] e;
    if (ram_en && ram_wea) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", ram_addr_w, ram_data_w);
      end else begin
        e = exp_q.pop_front();
        check("write", {40'd0, ram_addr_w, ram_data_w}, {40'd0, e});
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ram_en_r) enr_cnt++;
  end

  task automatic fill(input logic [7:0] xv, input logic [7:0] wv,
                      input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    for (int k = 0; k < 48; k++) xmem[k] = xv;
    for (int i = 0; i < 12 * 48; i++) wmem[W_BASE + i] = wv;
    for (int m = 0; m < 12; m++) begin
      qmem[Q_BASE + 3*m]     = v0;
      qmem[Q_BASE + 3*m + 1] = v1;
      qmem[Q_BASE + 3*m + 2] = v2;
    end
  endtask

  task automatic push_exp(input logic [7:0] e [12], input int cnt);
    for (int m = 0; m < cnt; m++) exp_q.push_back({16'h8000 + 16'(m), e[m]});
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    wr_cnt = 0; done_cnt = 0; enr_cnt = 0;
    check("busy_before", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input bool_poke);
    bit seen = 0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 1000 cycles");
    end
    if (bool_poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_at_done_ignored", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("still_idle", {63'd0, busy}, 64'd0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_checks(input int en_exp);
    check("done_cycle", 64'(done_cyc - s_cyc), 64'd721);
    check("write_count", 64'(wr_cnt), 64'd12);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("ram_en_r_cycles", 64'(enr_cnt), 64'(en_exp));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  logic [7:0] ev [12];

  initial begin
    for (int i = 0; i < 65536; i++) begin xmem[i] = 8'h00; wmem[i] = 8'h00; end
    for (int i = 0; i < 512; i++) qmem[i] = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_ctrl", {57'd0, busy, done, ram_en_r, rom_en_w, rom_en_q, ram_en, ram_wea}, 64'd0);
    check("reset_addr", {ram_addr_r, rom_addr_w, ram_addr_w, 7'd0, rom_addr_q}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero input: every neuron saturates low; start poked during done.
    fill(8'h00, 8'h05, 32'h4000_0000, 32'h0, 32'h0);
    for (int m = 0; m < 12; m++) ev[m] = 8'h80;
    push_exp(ev, 12);
    launch();
    wait_done(1);
    run_checks(EXP_EN);

    // Unit inputs and weights: acc=48, r=12, out=-116; start re-pulsed mid-run.
    fill(8'h01, 8'h01, 32'h4000_0000, 32'h0, 32'h0);
    for (int m = 0; m < 12; m++) ev[m] = 8'h8C;
    push_exp(ev, 12);
    launch();
    while (cyc < s_cyc + 100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0);
    run_checks(EXP_EN);

    // Large products: r=193548 saturates high.
    fill(8'h7F, 8'h7F, 32'h4000_0000, 32'h0, 32'h0);
    for (int m = 0; m < 12; m++) ev[m] = 8'h7F;
    push_exp(ev, 12);
    launch();
    wait_done(0);
    run_checks(EXP_EN);

    // Reset during neuron 4's MAC: four writes land, then nothing.
    push_exp(ev, 4);
    launch();
    while (cyc < s_cyc + 290) @(negedge clk);
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {57'd0, busy, done, ram_en_r, rom_en_w, rom_en_q, ram_en, ram_wea}, 64'd0);
    check("async_reset_addr", {ram_addr_r, rom_addr_w, ram_addr_w, 7'd0, rom_addr_q}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("writes_before_reset", 64'(wr_cnt), 64'd4);
    check("idle_after_reset", {63'd0, busy}, 64'd0);
    check("queue_after_reset", 64'(exp_q.size()), 64'd0);

    // Directed per-neuron requantization: rounding, zero correction, bias, boundaries.
    fill(8'h00, 8'h55, 32'h4000_0000, 32'h0, 32'h0);
    xmem[0] = 8'h01;
    xmem[1] = 8'h01;
    for (int m = 0; m < 12; m++) begin
      wmem[W_BASE + 48*m]     = (m < 4) ? 8'h01 : (m == 4) ? 8'hFF : 8'h00;
      wmem[W_BASE + 48*m + 1] = (m < 4) ? 8'h01 : (m == 4) ? 8'hFF : 8'h00;
    end
    qmem[Q_BASE + 3*1 + 1] = 32'd3;
    qmem[Q_BASE + 3*2 + 2] = 32'd510;
    qmem[Q_BASE + 3*3]     = 32'h7FFF_FFFF;
    qmem[Q_BASE + 3*3 + 2] = 32'd198;
    qmem[Q_BASE + 3*4 + 2] = 32'd300;
    qmem[Q_BASE + 3*5 + 2] = 32'd1020;
    qmem[Q_BASE + 3*6 + 2] = 32'd1016;
    ev = '{8'h81, 8'h80, 8'h00, 8'hE4, 8'hCB, 8'h7F, 8'h7E, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    push_exp(ev, 12);
    launch();
    wait_done(0);
    run_checks(EXP_EN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end
endmodule
